imm_ext_arbiter: RTL and testbench

- Shares one registered immediate-extension datapath between two pipeline requesters: req0 is decode-stage ALU immediates, req1 is branch-offset generation.
- Arbitrates round-robin and applies the requested extension mode.
- Presents the 16-bit result through a valid/ready output with 1-cycle latency.
- Sits between decode/branch units and the operand mux of the 16-bit pipelined RISC core.

---
 rtl/imm_ext_arbiter.sv | 102 ++++++++++
 tb/tb_imm_ext_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one registered immediate-extension stage between
// decode ALU immediates (req0) and branch-offset generation (req1).
//
// state | meaning
// EMPTY | output register holds no result, any request may be accepted
// FULL  | out_data holds a result awaiting out_ready
module imm_ext_arbiter #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic [1:0]        req0_mode,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [IMM_W-1:0]  req1_imm,
  input  logic [1:0]        req1_mode,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   can_accept;
  logic   gnt0, gnt1;

  function automatic logic [DATA_W-1:0] ext(input logic [IMM_W-1:0] imm,
                                            input logic [1:0] mode);
    logic [DATA_W-1:0] sx;
    sx = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (mode)
      2'b00:   ext = sx;
      2'b01:   ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      2'b10:   ext = {sx[DATA_W-2:0], 1'b0};
      default: ext = {imm, {(DATA_W-IMM_W){1'b0}}};
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    can_accept = (state == EMPTY) || out_ready;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    if (can_accept) begin
      // On a tie the requester that did not win last time goes next
      if (req0_valid && req1_valid) begin
        if (last_grant) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0 || gnt1) state_nxt = FULL;
    else if (can_accept) state_nxt = EMPTY;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign out_valid  = (state == FULL);

  // out_data is only ever loaded, so it holds its last value after draining
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= 1'b1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (gnt0) begin
      out_data   <= ext(req0_imm, req0_mode);
      out_src    <= 1'b0;
      last_grant <= 1'b0;
      grant_cnt0 <= grant_cnt0 + CNT_W'(1);
    end else if (gnt1) begin
      out_data   <= ext(req1_imm, req1_mode);
      out_src    <= 1'b1;
      last_grant <= 1'b1;
      grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed and randomized checks of imm_ext_arbiter against an arithmetic
// reference model of arbitration, extension and grant counting.
module tb_imm_ext_arbiter;
  localparam int DATA_W = 16;
  localparam int IMM_W  = 4;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic [IMM_W-1:0]  req0_imm, req1_imm;
  logic [1:0]        req0_mode, req1_mode;
  logic              req0_ready, req1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

  imm_ext_arbiter #(.DATA_W(DATA_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_mode(req0_mode), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_mode(req1_mode), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_valid;
  int          m_data;
  int          m_src;
  int          m_cnt0, m_cnt1;
  int          m_last;
  int          last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_ext(input int imm, input int mode);
    int s;
    int full;
    full = 1 << DATA_W;
    s = (imm >= (1 << (IMM_W-1))) ? imm - (1 << IMM_W) : imm;
    case (mode)
      0:       return (s + full) % full;
      1:       return imm;
      2:       return (s * 2 + full) % full;
      default: return imm * (1 << (DATA_W-IMM_W));
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 0; m_src = 0;
    m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"},  32'(out_data),  m_data);
    check({tag, ".out_src"},   32'(out_src),   m_src);
    check({tag, ".cnt0"},      32'(grant_cnt0), m_cnt0);
    check({tag, ".cnt1"},      32'(grant_cnt1), m_cnt1);
  endtask

  task automatic step(input logic v0, input int i0, input int md0,
                      input logic v1, input int i1, input int md1,
                      input logic ordy, input string tag);
    int g;
    @(negedge clock);
    req0_valid = v0; req0_imm = IMM_W'(i0); req0_mode = 2'(md0);
    req1_valid = v1; req1_imm = IMM_W'(i1); req1_mode = 2'(md1);
    out_ready  = ordy;
    #1;
    g = -1;
    if (!m_valid || ordy) begin
      if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
      else if (v0)   g = 0;
      else if (v1)   g = 1;
    end
    check({tag, ".req0_ready"}, 32'(req0_ready), 32'(g == 0));
    check({tag, ".req1_ready"}, 32'(req1_ready), 32'(g == 1));
    @(posedge clock);
    if (g == 0) begin
      m_data = model_ext(i0 % 16, md0 % 4); m_src = 0; m_valid = 1'b1;
      m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W); m_last = 0;
    end else if (g == 1) begin
      m_data = model_ext(i1 % 16, md1 % 4); m_src = 1; m_valid = 1'b1;
      m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W); m_last = 1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int exp_m[4];
    int saved;
    int c0, c1;
    logic p0, p1, v0, v1;

    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_imm = '0; req1_imm = '0; req0_mode = '0; req1_mode = '0;
    out_ready = 1'b0;
    model_reset();
    last_g = -1;
    #12;
    check_outputs("por");
    @(negedge clock);
    reset = 1'b0;

    // first transfer, sign-extend of 1010
    step(1, 10, 0, 0, 0, 0, 1, "first");
    check("first.data_const", 32'(out_data), 32'h0000_FFFA);
    check("first.cnt0_const", 32'(grant_cnt0), 32'd1);

    // req1, imm 0110, every mode back to back
    exp_m[0] = 16'h0006; exp_m[1] = 16'h0006; exp_m[2] = 16'h000C; exp_m[3] = 16'h6000;
    for (int m = 0; m < 4; m++) begin
      step(0, 0, 0, 1, 6, m, 1, "modes");
      check("modes.data_const", 32'(out_data), exp_m[m]);
    end

    step(0, 0, 0, 1, 8, 2, 1, "m10_neg");
    check("m10_neg.const", 32'(out_data), 32'h0000_FFF0);
    step(1, 8, 1, 0, 0, 0, 1, "m01_neg");
    check("m01_neg.const", 32'(out_data), 32'h0000_0008);

    // make req1 last winner, then contend for 6 cycles
    step(0, 0, 0, 1, 3, 0, 1, "pre_rr");
    c0 = m_cnt0; c1 = m_cnt1;
    for (int k = 0; k < 6; k++) begin
      step(1, k, k % 4, 1, 15 - k, (k + 1) % 4, 1, "rr");
      check("rr.grant_seq", 32'(last_g), 32'(k % 2));
    end
    check("rr.cnt0_delta", 32'(grant_cnt0), 32'(c0 + 3));
    check("rr.cnt1_delta", 32'(grant_cnt1), 32'(c1 + 3));

    // stall with output full
    saved = m_data;
    for (int k = 0; k < 4; k++) begin
      step(1, k + 2, k % 4, 1, k + 9, 3, 0, "stall");
      check("stall.data_stable", 32'(out_data), saved);
    end
    step(1, 5, 0, 1, 7, 3, 1, "unstall");
    check("unstall.granted", 32'(last_g >= 0), 32'd1);

    // reset in the middle of a transfer
    @(negedge clock);
    req0_valid = 1'b1; req0_imm = 4'd3; req0_mode = 2'd0;
    req1_valid = 1'b1; req1_imm = 4'd4; req1_mode = 2'd1;
    out_ready  = 1'b1;
    #1;
    check("midrst.transfer_pending", 32'(req0_ready | req1_ready), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("midrst.async");
    @(posedge clock);
    #1;
    check_outputs("midrst.edge");
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    step(1, 1, 0, 1, 2, 0, 1, "post_rst_tie");
    check("post_rst_tie.winner", 32'(last_g), 32'd0);

    // 256 grants to req0 wrap the counter
    do_reset();
    for (int k = 0; k < 256; k++)
      step(1, $urandom_range(15), $urandom_range(3), 0, 0, 0, 1, "wrap");
    check("wrap.cnt0_zero", 32'(grant_cnt0), 32'd0);

    // randomized traffic; a pending requester keeps valid until accepted
    p0 = 1'b0; p1 = 1'b0;
    for (int k = 0; k < 400; k++) begin
      v0 = p0 | ($urandom_range(99) < 60);
      v1 = p1 | ($urandom_range(99) < 60);
      step(v0, $urandom_range(15), $urandom_range(3),
           v1, $urandom_range(15), $urandom_range(3),
           logic'($urandom_range(99) < 70), "rand");
      p0 = v0 && (last_g != 0);
      p1 = v1 && (last_g != 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
